control_multiciclo: RTL
=======================

# control_multiciclo

Multicycle MIPS32 control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clock cycles. It drives the shared-datapath muxes, the single unified memory port and the PC/IR write enables. It waits on a memory-ready handshake and flags illegal opcodes. It sits between the instruction register's opcode field and the multicycle datapath, and succeeds the single-cycle control decoder.

## Interface
- BYTE_EN, 1: 1 = LB/LBU/SB legal; 0 = those opcodes are treated as illegal.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  6  instr[31:26] from the IR; sampled only in DECODE.
- mem_ready  in  1  memory has completed the current access.
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDest  out  1 each  datapath controls.
- ALUOp  out  2  ALU operation class: 00 add, 01 subtract/compare, 10 R-type funct, 11 logic immediate.
- ALUSrcB  out  2  ALU B-input select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 immediate shifted left by 2.
- PCSource  out  2  PC source select: 00 ALU result, 01 ALUOut, 10 jump target.
- branch_ne  out  1  invert the zero test; used for BNE.
- is_byte, is_unsigned  out  1 each  byte-access qualifiers.
- instr_done  out  1  one-cycle pulse in the final state of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode.

## Operation
- States, 4-bit, in the shared package: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP.
- Opcodes:
  - R-type 000000
  - LW 100011, SW 101011
  - LB 100000 (signed), LBU 100100 (unsigned), SB 101000
  - BEQ 000100, BNE 000101
  - J 000010
  - ADDI 001000, ANDI 001100, ORI 001101
- DECODE latches opcode into op_q; all later states use op_q only.
- Every output defaults to 0 in every state; the list below gives only the asserted values.
- IDLE: all outputs 0. Always goes to FETCH.
- FETCH: MemRead=1, ALUSrcB=01.
  - IRWrite=1 and PCWrite=1 only while mem_ready=1 (Mealy on mem_ready).
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE: ALUSrcB=11 (computes the branch target). Next state by opcode:
  - LW/LB/LBU/SW/SB -> MEM_ADDR
  - R-type -> EXEC_R
  - ADDI/ANDI/ORI -> EXEC_I
  - BEQ/BNE -> BRANCH
  - J -> JUMP
  - anything else -> FETCH, with illegal_op=1
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10. Loads go to MEM_READ, stores to MEM_WRITE.
- MEM_READ: MemRead=1, IorD=1. Held until mem_ready=1, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, instr_done=1. Then FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Held until mem_ready=1. instr_done=1 in the exit cycle; then FETCH.
- EXEC_R: ALUSrcA=1, ALUOp=10. Then R_WB.
- R_WB: RegDest=1, RegWrite=1, instr_done=1. Then FETCH.
- EXEC_I: ALUSrcA=1, ALUSrcB=10. ALUOp=00 for ADDI, 11 for ANDI/ORI. Then I_WB.
- I_WB: RegWrite=1, instr_done=1. Then FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, branch_ne=(op_q==BNE), instr_done=1. Then FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Then FETCH.
- Byte qualifiers, asserted in MEM_ADDR, MEM_READ, MEM_WB and MEM_WRITE:
  - is_byte=1 for LB, LBU, SB.
  - is_unsigned=1 for LBU only.

## Timing
- Reset: asynchronous entry to IDLE; every output is 0 while rst=1 and in the IDLE cycle.
- Deasserting rst takes effect on the next clk edge; the first fetch begins one cycle after IDLE.
- Latency with mem_ready tied high, in cycles:
  - R-type 4, I-type 4, LW/LB/LBU 5, SW/SB 4, BEQ/BNE 3, J 3.
  - Illegal opcode: 2 (FETCH, DECODE) before the next fetch.
- Each memory wait cycle adds 1 cycle in FETCH, MEM_READ or MEM_WRITE; there is no timeout.
- mem_ready outside FETCH, MEM_READ and MEM_WRITE is ignored.
- Reset asserted mid-instruction aborts immediately: no write enable survives the reset edge, and op_q clears to 0.

## Structure
- Package control_pkg holds the opcode localparams, the state encoding, and the ALUOp, ALUSrcB and PCSource codes.
- One sub-module, control_salidas: a combinational state + op_q + mem_ready -> outputs decoder.
- The top level holds the state register, op_q and the next-state logic.

## Test plan
- R-type, mem_ready=1: states IDLE, FETCH, DECODE, EXEC_R, R_WB. RegDest=RegWrite=1 in cycle 4; instr_done pulses once.
- LB with mem_ready low for 2 cycles in MEM_READ: MemRead, IorD and is_byte held 3 cycles, is_unsigned=0; MEM_WB follows. LBU gives is_unsigned=1.
- BNE: BRANCH state has PCWriteCond=1, PCSource=01, branch_ne=1, ALUOp=01; BEQ gives branch_ne=0.
- Opcode 111111: illegal_op pulses in DECODE and FETCH follows; with BYTE_EN=0, opcode 101000 also raises illegal_op.
- rst asserted in MEM_WRITE: MemWrite drops to 0 asynchronously, then IDLE -> FETCH after release.
- FETCH with mem_ready=0 for 3 cycles: IRWrite and PCWrite stay 0, then are 1 for exactly the mem_ready cycle.

Source files
------------

// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - opcodes, state encoding and control field codes for the multicycle control unit
package control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_LOG = 2'b11;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU  = 2'b00;
    localparam logic [1:0] PCSRC_OUT  = 2'b01;
    localparam logic [1:0] PCSRC_JUMP = 2'b10;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE,
        EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP
    } state_t;

    function automatic logic is_byte_op(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
    endfunction

    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/control_salidas.sv
// rtl/control_salidas.sv - combinational state/op_q/mem_ready to datapath control decoder
module control_salidas
    import control_pkg::*;
(
    input  logic       [5:0] op_q,
    input  state_t           state,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             RegDest,
    output logic       [1:0] ALUOp,
    output logic       [1:0] ALUSrcB,
    output logic       [1:0] PCSource,
    output logic             branch_ne,
    output logic             is_byte,
    output logic             is_unsigned,
    output logic             instr_done
);

    logic mem_phase;

    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDest     = 1'b0;
        ALUOp       = ALUOP_ADD;
        ALUSrcB     = SRCB_REG;
        PCSource    = PCSRC_ALU;
        branch_ne   = 1'b0;
        instr_done  = 1'b0;
        mem_phase   = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = SRCB_SHL2;
            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                mem_phase = 1'b1;
            end
            MEM_READ: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                mem_phase = 1'b1;
            end
            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                mem_phase  = 1'b1;
            end
            MEM_WRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                mem_phase  = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALUOP_R;
            end
            R_WB: begin
                RegDest    = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = (op_q == OP_ADDI) ? ALUOP_ADD : ALUOP_LOG;
            end
            I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_OUT;
                branch_ne   = (op_q == OP_BNE);
                instr_done  = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        is_byte     = mem_phase && is_byte_op(op_q);
        is_unsigned = mem_phase && (op_q == OP_LBU);
    end

endmodule

// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multicycle MIPS32 control unit: state register, op_q latch, next-state logic
module control_multiciclo
    import control_pkg::*;
#(
    parameter bit BYTE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDest,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       branch_ne,
    output logic       is_byte,
    output logic       is_unsigned,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t     state;
    state_t     state_next;
    logic [5:0] op_q;
    logic       byte_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= state_next;
            if (state == DECODE)
                op_q <= opcode;
        end
    end

    // Byte opcodes fall through to the illegal path when byte lanes are not built.
    assign byte_ok = BYTE_EN || !is_byte_op(opcode);

    always_comb begin
        state_next = state;
        illegal_op = 1'b0;
        case (state)
            IDLE:  state_next = FETCH;
            FETCH: if (mem_ready) state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB: state_next = byte_ok ? MEM_ADDR : FETCH;
                    OP_RTYPE:                           state_next = EXEC_R;
                    OP_ADDI, OP_ANDI, OP_ORI:           state_next = EXEC_I;
                    OP_BEQ, OP_BNE:                     state_next = BRANCH;
                    OP_J:                               state_next = JUMP;
                    default:                            state_next = FETCH;
                endcase
                illegal_op = (state_next == FETCH);
            end
            MEM_ADDR:  state_next = is_load(op_q) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_next = MEM_WB;
            MEM_WRITE: if (mem_ready) state_next = FETCH;
            EXEC_R:    state_next = R_WB;
            EXEC_I:    state_next = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP: state_next = FETCH;
            default:   state_next = IDLE;
        endcase
    end

    control_salidas u_salidas (
        .op_q        (op_q),
        .state       (state),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .ALUSrcA     (ALUSrcA),
        .RegWrite    (RegWrite),
        .RegDest     (RegDest),
        .ALUOp       (ALUOp),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .branch_ne   (branch_ne),
        .is_byte     (is_byte),
        .is_unsigned (is_unsigned),
        .instr_done  (instr_done)
    );

endmodule
